// File: rtl/scrypt_pkg.sv
// Shared types and constants for the scrypt ROMix engine and its scratchpad.
package scrypt_pkg;

  localparam int BLOCK_W   = 1024;
  localparam int N_DEFAULT = 1024;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    F_WAIT,
    MIX_RD,
    MIX_XOR,
    MIX_GO,
    MIX_WAIT,
    DONE
  } romix_state_t;

endpackage

// File: rtl/scrypt_romix_if.sv
// Enable/done handshake between ROMix (master) and the external BlockMix (slave).
interface scrypt_romix_if;
  import scrypt_pkg::*;

  logic [BLOCK_W-1:0] bm_data;
  logic               bm_enable;
  logic [BLOCK_W-1:0] bm_hash_out;
  logic               bm_hash_done;

  modport master (
    output bm_data,
    output bm_enable,
    input  bm_hash_out,
    input  bm_hash_done
  );

  modport slave (
    input  bm_data,
    input  bm_enable,
    output bm_hash_out,
    output bm_hash_done
  );

endinterface

// File: rtl/scrypt_romix_scratchpad.sv
// Single-port N x BLOCK_W synchronous RAM holding V[], one-cycle read latency.
module scrypt_scratchpad
  import scrypt_pkg::*;
#(
  parameter int N      = N_DEFAULT,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [BLOCK_W-1:0] wdata,
  output logic [BLOCK_W-1:0] rdata
);

  logic [BLOCK_W-1:0] mem [N];
  logic [BLOCK_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/scrypt_romix.sv
// scrypt ROMix sequencer: fills V[] with successive BlockMix outputs, then mixes
// X with data-dependent reads of V[] for N more BlockMix rounds.
module scrypt_romix
  import scrypt_pkg::*;
#(
  parameter int N      = N_DEFAULT,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BLOCK_W-1:0] data_in,
  input  logic               start,
  output logic               busy,
  output logic [BLOCK_W-1:0] hash_out,
  output logic               hash_done,
  scrypt_romix_if.master     bm
);

  localparam logic [ADDR_W-1:0] I_LAST = ADDR_W'(N - 1);

  romix_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  i_q, i_d;
  logic [BLOCK_W-1:0] x_q, x_d;
  logic [BLOCK_W-1:0] hash_out_q, hash_out_d;
  logic               hash_done_q, hash_done_d;

  logic               sp_we;
  logic [ADDR_W-1:0]  sp_addr;
  logic [BLOCK_W-1:0] sp_rdata;

  scrypt_scratchpad #(
    .N      (N),
    .ADDR_W (ADDR_W)
  ) u_scratchpad (
    .clk   (clk),
    .we    (sp_we),
    .addr  (sp_addr),
    .wdata (x_q),
    .rdata (sp_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      i_q         <= '0;
      x_q         <= '0;
      hash_out_q  <= '0;
      hash_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      x_q         <= x_d;
      hash_out_q  <= hash_out_d;
      hash_done_q <= hash_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    i_d          = i_q;
    x_d          = x_q;
    hash_out_d   = hash_out_q;
    hash_done_d  = 1'b0;
    sp_we        = 1'b0;
    sp_addr      = x_q[ADDR_W-1:0];
    bm.bm_enable = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = data_in;
          i_d     = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        sp_we        = 1'b1;
        sp_addr      = i_q;
        bm.bm_enable = 1'b1;
        state_d      = F_WAIT;
      end
      F_WAIT: begin
        if (bm.bm_hash_done) begin
          x_d = bm.bm_hash_out;
          if (i_q == I_LAST) begin
            i_d     = '0;
            state_d = MIX_RD;
          end else begin
            i_d     = i_q + 1'b1;
            state_d = FILL;
          end
        end
      end
      MIX_RD: begin
        state_d = MIX_XOR;
      end
      MIX_XOR: begin
        x_d     = x_q ^ sp_rdata;
        state_d = MIX_GO;
      end
      MIX_GO: begin
        bm.bm_enable = 1'b1;
        state_d      = MIX_WAIT;
      end
      MIX_WAIT: begin
        if (bm.bm_hash_done) begin
          x_d = bm.bm_hash_out;
          if (i_q == I_LAST) begin
            // Result registered on the last handshake so it is valid in DONE alongside the pulse.
            hash_out_d  = bm.bm_hash_out;
            hash_done_d = 1'b1;
            state_d     = DONE;
          end else begin
            i_d     = i_q + 1'b1;
            state_d = MIX_RD;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign hash_out   = hash_out_q;
  assign hash_done  = hash_done_q;
  assign bm.bm_data = x_q;

endmodule

// File: doc/scrypt_romix.md
SCRYPT_ROMIX -- requirements
Module: scrypt_romix

Interface
REQ-001 SHALL have parameter N, default 1024: scratchpad depth and iteration count; power of two, >= 2.
REQ-002 SHALL have parameter ADDR_W, default $clog2(N): scratchpad address width.
REQ-003 SHALL have port clk  input  1: single clock; all logic on the rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-005 SHALL have port data_in  input  1024: initial block X, sampled only in the start-accept cycle.
REQ-006 SHALL have port start  input  1: request; accepted only in IDLE.
REQ-007 SHALL have port busy  output  1: high whenever the state is not IDLE.
REQ-008 SHALL have port hash_out  output  1024: final X; holds its value between runs.
REQ-009 SHALL have port hash_done  output  1: one-cycle pulse when hash_out is valid.
REQ-010 SHALL have port bm_data  output  1024: block sent to the external blockmix.
REQ-011 SHALL have port bm_enable  output  1: one-cycle blockmix launch pulse.
REQ-012 SHALL have port bm_hash_out  input  1024: blockmix result.
REQ-013 SHALL have port bm_hash_done  input  1: blockmix completion pulse.

Function
REQ-014 SHALL implement the scrypt ROMix algorithm.
- Phase 1, for i = 0..N-1: V[i] = X, then X = BlockMix(X).
- Phase 2, N times: j = X[ADDR_W-1:0], then X = BlockMix(X ^ V[j]).
REQ-015 SHALL use states IDLE, FILL, F_WAIT, MIX_RD, MIX_XOR, MIX_GO, MIX_WAIT, DONE.
REQ-016 IDLE: when start=1, SHALL load X<=data_in and i<=0, then go to FILL.
REQ-017 FILL: SHALL write V[i]=X, drive bm_data=X with bm_enable=1, then go to F_WAIT.
REQ-018 F_WAIT, on bm_hash_done: SHALL load X<=bm_hash_out.
- If i==N-1: i<=0, go to MIX_RD.
- Otherwise: i<=i+1, go to FILL.
REQ-019 MIX_RD: SHALL issue a scratchpad read at address X[ADDR_W-1:0], then go to MIX_XOR (read latency is 1 cycle).
REQ-020 MIX_XOR: SHALL load X<=X^rdata, then go to MIX_GO.
REQ-021 MIX_GO: SHALL drive bm_enable=1, then go to MIX_WAIT.
REQ-022 MIX_WAIT, on bm_hash_done: SHALL load X<=bm_hash_out.
- If i==N-1: go to DONE.
- Otherwise: i<=i+1, go to MIX_RD.
REQ-023 DONE: SHALL load hash_out<=X, pulse hash_done for exactly one cycle, then go to IDLE.
REQ-024 bm_data SHALL equal X in every cycle, held stable from bm_enable through bm_hash_done.
REQ-025 bm_enable SHALL be high only in FILL and MIX_GO.
REQ-026 start SHALL be ignored while busy; changes on data_in after the accept cycle SHALL have no effect.
REQ-027 bm_hash_done SHALL be ignored outside F_WAIT and MIX_WAIT.
REQ-028 Iteration counter i SHALL be ADDR_W bits wide and compared against N-1, with no wrap past it.
REQ-029 Cycles per iteration, where Lbm = cycles from bm_enable to bm_hash_done:
- Phase 1: 1+Lbm.
- Phase 2: 3+Lbm.

Reset
REQ-030 On rst=1 at a clock edge, the block SHALL apply these values:
- state IDLE, i=0, X=0.
- hash_out=0, hash_done=0, bm_enable=0, busy=0.
REQ-031 Reset mid-operation SHALL abort with no hash_done pulse; scratchpad contents need not be cleared.
REQ-032 A start in the first cycle after reset deasserts SHALL be accepted.

Structure
REQ-033 Package scrypt_pkg SHALL hold the following:
- romix_state_t enum.
- BLOCK_W=1024.
- Default N.
REQ-034 Sub-module scrypt_scratchpad SHALL be a single-port synchronous RAM with these properties:
- N x BLOCK_W.
- 1-cycle read latency.
- Write-enable.
REQ-035 Blockmix SHALL stay external; this block is the initiator side of its enable/hash_done handshake.

Verification
REQ-036 Bench SHALL use N=4 and a blockmix model returning in+1 (1024-bit add), with bm_hash_done exactly 5 cycles after bm_enable.
REQ-037 Scenario, basic run:
- Stimulus: data_in=0, start pulsed at cycle 0.
- Response: busy=1 from cycle 1; hash_done pulse at cycle 57; hash_out=5.
REQ-038 Scenario, reset:
- Stimulus: rst high for 2 cycles with start=1.
- Response: busy=0, hash_done=0, bm_enable=0, hash_out=0.
REQ-039 Scenario, start while busy:
- Stimulus: start pulsed at cycle 10 with data_in=all-ones.
- Response: ignored; hash_out=5 at cycle 57; an immediate re-start after DONE runs normally.
REQ-040 Scenario, reset mid-operation:
- Stimulus: rst at cycle 30 (phase 2), then start with data_in=0.
- Response: no hash_done before the new run; new run yields hash_out=5 after 57 cycles.
REQ-041 Scenario, stray inputs:
- Stimulus: bm_hash_done pulsed in IDLE and in MIX_RD; data_in toggled during the run.
- Response: state and result are unaffected (hash_out=5).
